compress_sequencer: RTL and testbench

Sequences one 256-coefficient polynomial through the external compress datapath for a selected compression width D (10 = du, 4 = dv, 1 = message).
- Reads coefficients from coefficient RAM by address.
- Drives the compress unit and sets its D.
- Packs the D-bit results LSB-first into 32-bit words.
- Streams those words to the ciphertext encoder over a valid/ready interface with full backpressure.

---
 rtl/compress_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_compress_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/compress_sequencer.sv
// -----------------------------------------------------------------------------
// compress_sequencer
//   Walks one N-coefficient polynomial through an external clocked compress
//   unit for a selected compression width D (10, 4 or 1). Coefficients are read
//   from RAM by address, the D-bit results are packed LSB-first into a 64-bit
//   accumulator, and 32-bit words are streamed out over valid/ready.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, mode       one-cycle request (sampled in IDLE); mode 0/1/2 -> D=10/4/1
//   busy, done, err   status: running, end-of-polynomial pulse, illegal-mode pulse
//   coef_rd_en/addr   coefficient RAM read strobe and index
//   coef_rdata        coefficient from RAM (MEM_LAT cycles after the strobe)
//   comp_in, comp_d   to the compress unit: coefficient pass-through and active D
//   comp_out          compressed value (COMP_LAT cycles after comp_in)
//   out_data/valid    packed word stream, held stable under backpressure
//   out_ready         downstream accept
// -----------------------------------------------------------------------------
module compress_sequencer #(
  parameter int N        = 256,
  parameter int MEM_LAT  = 1,
  parameter int COMP_LAT = 1,
  parameter int W        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 coef_rd_en,
  output logic [$clog2(N)-1:0] coef_addr,
  input  logic [11:0]          coef_rdata,
  output logic [11:0]          comp_in,
  output logic [3:0]           comp_d,
  input  logic [9:0]           comp_out,
  output logic [W-1:0]         out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int AW    = $clog2(N);
  localparam int LAT   = MEM_LAT + COMP_LAT;
  localparam int ACC_W = 2 * W;
  localparam int FW    = $clog2(ACC_W + 1);
  localparam int IFW   = $clog2(LAT + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       d_q, d_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LAT-1:0]   tag_q, tag_d;
  logic [IFW-1:0]   inflight_q, inflight_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             err_q, err_d;

  logic             pop_s;
  logic             ret_s;
  logic             issue_s;
  logic [FW-1:0]    fill_pop_s;
  logic [ACC_W-1:0] acc_pop_s;
  logic [15:0]      need_s;

  function automatic logic [3:0] mode_to_d(input logic [1:0] m);
    case (m)
      2'd0:    mode_to_d = 4'd10;
      2'd1:    mode_to_d = 4'd4;
      2'd2:    mode_to_d = 4'd1;
      default: mode_to_d = 4'd10;
    endcase
  endfunction

  // Keep only the low D bits; the compress unit may leave junk above them.
  function automatic logic [9:0] mask_res(input logic [9:0] v, input logic [3:0] d);
    case (d)
      4'd4:    mask_res = {6'b0, v[3:0]};
      4'd1:    mask_res = {9'b0, v[0]};
      default: mask_res = v;
    endcase
  endfunction

  // Next-state, read issue and packer update.
  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    addr_d   = addr_q;
    err_d    = 1'b0;
    issue_s  = 1'b0;

    pop_s      = (fill_q >= FW'(W)) && out_ready;
    ret_s      = tag_q[LAT-1];
    fill_pop_s = pop_s ? (fill_q - FW'(W)) : fill_q;
    acc_pop_s  = pop_s ? (acc_q >> W) : acc_q;
    // Reserve room for every outstanding result plus the one about to issue,
    // so a returning result always fits and nothing stalls in the pipeline.
    need_s     = 16'(fill_pop_s) + 16'(d_q) * (16'(inflight_q) + 16'd1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode == 2'd3) begin
            err_d = 1'b1;
          end else begin
            d_d     = mode_to_d(mode);
            addr_d  = '0;
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (need_s <= 16'(ACC_W)) begin
          issue_s = 1'b1;
          addr_d  = addr_q + AW'(1);
          if (addr_q == AW'(N - 1)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      S_DRAIN: begin
        if ((inflight_q == '0) && (fill_q == '0)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Tag bit i set means a read issued i+1 cycles ago; the top bit marks the
    // cycle its compressed result is on comp_out.
    tag_d      = LAT'({tag_q, issue_s});
    inflight_d = inflight_q + IFW'(issue_s) - IFW'(ret_s);

    if (ret_s) begin
      acc_d  = acc_pop_s | (ACC_W'(mask_res(comp_out, d_q)) << fill_pop_s);
      fill_d = fill_pop_s + FW'(d_q);
    end else begin
      acc_d  = acc_pop_s;
      fill_d = fill_pop_s;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      d_q        <= 4'd10;
      addr_q     <= '0;
      tag_q      <= '0;
      inflight_q <= '0;
      acc_q      <= '0;
      fill_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      addr_q     <= addr_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      err_q      <= err_d;
    end
  end

  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign coef_rd_en = issue_s;
  assign coef_addr  = addr_q;
  assign comp_in    = coef_rdata;
  assign comp_d     = d_q;
  assign out_data   = acc_q[W-1:0];
  assign out_valid  = (fill_q >= FW'(W));

endmodule

// File: tb/tb_compress_sequencer.sv
module tb_compress_sequencer;

  localparam int N = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       busy, done, err, coef_rd_en;
  logic [7:0] coef_addr;
  logic [11:0] coef_rdata = 12'd0;
  logic [11:0] comp_in;
  logic [3:0]  comp_d;
  logic [9:0]  comp_out = 10'd0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  compress_sequencer #(.N(N), .MEM_LAT(1), .COMP_LAT(1), .W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .err(err),
    .coef_rd_en(coef_rd_en), .coef_addr(coef_addr), .coef_rdata(coef_rdata),
    .comp_in(comp_in), .comp_d(comp_d), .comp_out(comp_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int unsigned mem [N];
  logic [31:0] exp_q [$];
  int          words_rx, done_cnt, err_cnt, exp_addr, rdy_mode, rdy_cyc;
  logic [31:0] first_word, stall_data;
  logic        stall_pend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned compress_f(input int unsigned x, input int unsigned d);
    return (((x << d) + 1664) / 3329) % (1 << d);
  endfunction

  // Coefficient RAM, one cycle read latency; junk when not reading.
  always @(posedge clk)
    coef_rdata <= coef_rd_en ? 12'(mem[coef_addr]) : 12'($urandom);

  // Clocked compress unit; bits above D are filled with junk.
  always @(posedge clk)
    comp_out <= 10'(compress_f(32'(comp_in), 32'(comp_d)) | ($urandom << comp_d));

  // Downstream sink and protocol monitor.
  always @(negedge clk) begin
    rdy_cyc++;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (rdy_cyc % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (stall_pend && !rst) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, stall_data);
    end
    stall_pend = out_valid && !out_ready;
    stall_data = out_data;
    if (out_valid && out_ready) begin
      if (words_rx == 0) first_word = out_data;
      words_rx++;
      chk("word_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("word", out_data, exp_q.pop_front());
    end
    if (coef_rd_en) begin
      chk("addr", coef_addr, exp_addr);
      exp_addr++;
    end
    if (done) begin
      done_cnt++;
      chk("busy_at_done", busy, 0);
    end
    if (err) err_cnt++;
    chk("fill_le_64", dut.fill_q <= 7'd64, 1);
  end

  task automatic load_mem(input int kind, input int unsigned cval);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       mem[i] = cval;
        1:       mem[i] = (i % 2 == 0) ? 1665 : 0;
        default: mem[i] = $urandom_range(0, 3328);
      endcase
    end
  endtask

  // Reference: list of D-bit compressed values as a flat LSB-first bit list.
  task automatic build_exp(input int d);
    bit bits [$];
    logic [31:0] wv;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      int unsigned v = compress_f(mem[i], d);
      for (int b = 0; b < d; b++) bits.push_back(bit'((v >> b) & 1));
    end
    for (int w = 0; w < bits.size() / 32; w++) begin
      wv = '0;
      for (int j = 0; j < 32; j++) wv[j] = bits[w * 32 + j];
      exp_q.push_back(wv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd_en"}, coef_rd_en, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_addr"}, coef_addr, 0);
    chk({tag, "_comp_d"}, comp_d, 10);
  endtask

  task automatic run(input logic [1:0] m, input int rmode, input int poke, input int rst_word);
    int cyc;
    int d;
    bit aborted;
    d = (m == 2'd0) ? 10 : (m == 2'd1) ? 4 : 1;
    words_rx = 0; done_cnt = 0; err_cnt = 0; exp_addr = 0; stall_pend = 1'b0;
    rdy_mode = rmode;
    build_exp(d);
    aborted = 1'b0;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    cyc   = 0;
    while (cyc < 4000) begin
      @(negedge clk);
      start = 1'b0;
      if (poke > 0 && cyc == poke) begin
        start = 1'b1; mode = 2'd1;
      end else if (poke > 0 && cyc == poke + 50) begin
        start = 1'b1; mode = 2'd3;
      end else begin
        mode = m;
      end
      cyc++;
      #2;
      if (cyc == 10) chk("comp_d", comp_d, d);
      if (rst_word > 0 && words_rx >= rst_word) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        aborted = 1'b1;
        break;
      end
      if (done_cnt > 0) break;
    end
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      #2;
      chk("no_done_after_rst", done_cnt, 0);
      chk("idle_after_rst", busy, 0);
    end else begin
      chk("done_seen", done_cnt, 1);
      chk("word_count", words_rx, N * d / 32);
      chk("exp_drained", exp_q.size(), 0);
      chk("err_none", err_cnt, 0);
      if (rmode == 0) chk("latency", cyc <= N + 2 + 4, 1);
      @(negedge clk);
      #2;
      chk("busy_after", busy, 0);
      chk("done_once", done_cnt, 1);
    end
  endtask

  initial begin
    rdy_mode = 0; rdy_cyc = 0; words_rx = 0; done_cnt = 0; err_cnt = 0;
    exp_addr = 0; stall_pend = 1'b0; first_word = '0; stall_data = '0;
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: constant 1310 at D=10
    load_mem(0, 1310);
    run(2'd0, 0, 0, 0);
    chk("t1_first_word", first_word, 32'hD9364D93);
    chk("t1_words", words_rx, 80);

    // 2: alternating 1665/0 at D=1
    load_mem(1, 0);
    run(2'd2, 0, 0, 0);
    chk("t2_first_word", first_word, 32'h55555555);
    chk("t2_words", words_rx, 8);

    // 3: zeros at D=4 with out_ready 1-of-3
    load_mem(0, 0);
    run(2'd1, 1, 0, 0);
    chk("t3_first_word", first_word, 32'h0);
    chk("t3_words", words_rx, 32);

    // 4: random coefficients, all modes, random backpressure
    for (int m = 0; m < 3; m++) begin
      load_mem(2, 0);
      run(2'(m), 2, 0, 0);
    end

    // 5: illegal mode in IDLE, then starts poked mid-run
    @(negedge clk);
    start = 1'b1; mode = 2'd3;
    @(negedge clk);
    start = 1'b0; mode = 2'd0;
    #2;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_rd_en", coef_rd_en, 0);
    @(negedge clk);
    #2;
    chk("err_one_cycle", err, 0);
    chk("err_still_idle", busy, 0);
    load_mem(2, 0);
    run(2'd0, 0, 50, 0);
    chk("t5_words", words_rx, 80);

    // 6: reset at word 20, then a clean D=10 run
    load_mem(2, 0);
    run(2'd0, 0, 0, 20);
    load_mem(2, 0);
    run(2'd0, 0, 0, 0);
    chk("t6_words", words_rx, 80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
